// File: rtl/instruction_fetch_unit.sv
// PC generation and fetch sequencing in front of a 1-cycle registered instruction memory.
// Optional FETCH_ALIGN_CHECK_EN adds a sticky fetch_misaligned flag and word-aligns redirect targets.
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] PC_STEP  = 32'd4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic [31:0] imem_address,
  input  logic [31:0] imem_instruction,
  output logic [31:0] if_pc,
  output logic [31:0] if_pc_plus4,
  output logic [31:0] if_instruction,
  output logic        if_valid,
  output logic [31:0] fetch_count
`ifdef FETCH_ALIGN_CHECK_EN
  ,
  output logic        fetch_misaligned
`endif
);

  typedef enum logic [1:0] {
    BOOT,
    RUN,
    HOLD
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_f_q, pc_f_d;
  logic [31:0] pc_d_q, pc_d_d;
  logic        valid_d_q, valid_d_d;
  logic [31:0] fetch_count_q, fetch_count_d;
  logic [31:0] target;

`ifdef FETCH_ALIGN_CHECK_EN
  logic fetch_misaligned_q, fetch_misaligned_d;

  assign target = {redirect_target[31:2], 2'b00};

  always_comb begin
    fetch_misaligned_d = fetch_misaligned_q;
    if (redirect_valid && (redirect_target[1:0] != 2'b00)) begin
      fetch_misaligned_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      fetch_misaligned_q <= 1'b0;
    end else begin
      fetch_misaligned_q <= fetch_misaligned_d;
    end
  end

  assign fetch_misaligned = fetch_misaligned_q;
`else
  assign target = redirect_target;
`endif

  // A stall replays pc_d so the registered memory keeps returning the held instruction.
  always_comb begin
    if (redirect_valid) begin
      imem_address = target;
    end else if (stall) begin
      imem_address = pc_d_q;
    end else begin
      imem_address = pc_f_q;
    end
  end

  always_comb begin
    state_d       = state_q;
    pc_f_d        = pc_f_q;
    pc_d_d        = pc_d_q;
    valid_d_d     = valid_d_q;
    fetch_count_d = fetch_count_q;

    if (redirect_valid || (valid_d_q && !stall)) begin
      fetch_count_d = fetch_count_q + 32'd1;
    end

    if (redirect_valid) begin
      pc_d_d    = target;
      pc_f_d    = target + PC_STEP;
      valid_d_d = 1'b1;
      state_d   = RUN;
    end else begin
      unique case (state_q)
        BOOT: begin
          if (stall) begin
            pc_f_d  = RESET_PC;
            state_d = HOLD;
          end else begin
            pc_d_d    = RESET_PC;
            pc_f_d    = RESET_PC + PC_STEP;
            valid_d_d = 1'b1;
            state_d   = RUN;
          end
        end
        RUN, HOLD: begin
          if (stall) begin
            state_d = HOLD;
          end else begin
            pc_d_d    = pc_f_q;
            pc_f_d    = pc_f_q + PC_STEP;
            valid_d_d = 1'b1;
            state_d   = RUN;
          end
        end
        default: begin
          state_d = BOOT;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q       <= BOOT;
      pc_f_q        <= RESET_PC;
      pc_d_q        <= RESET_PC;
      valid_d_q     <= 1'b0;
      fetch_count_q <= 32'd0;
    end else begin
      state_q       <= state_d;
      pc_f_q        <= pc_f_d;
      pc_d_q        <= pc_d_d;
      valid_d_q     <= valid_d_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  assign if_pc          = pc_d_q;
  assign if_pc_plus4    = pc_d_q + PC_STEP;
  assign if_instruction = imem_instruction;
  assign if_valid       = valid_d_q;
  assign fetch_count    = fetch_count_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit with a registered instruction-memory model.
// Covers boot, stall/replay, redirects, reset in HOLD, PC wraparound and the optional alignment flag.
module tb_instruction_fetch_unit;

  logic        clk;
  logic        resetn;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic [31:0] imem_address;
  logic [31:0] imem_instruction;
  logic [31:0] if_pc;
  logic [31:0] if_pc_plus4;
  logic [31:0] if_instruction;
  logic        if_valid;
  logic [31:0] fetch_count;
`ifdef FETCH_ALIGN_CHECK_EN
  logic        fetch_misaligned;
`endif

  int vectors;
  int miscompares;

  instruction_fetch_unit dut (
    .clk              (clk),
    .resetn           (resetn),
    .stall            (stall),
    .redirect_valid   (redirect_valid),
    .redirect_target  (redirect_target),
    .imem_address     (imem_address),
    .imem_instruction (imem_instruction),
    .if_pc            (if_pc),
    .if_pc_plus4      (if_pc_plus4),
    .if_instruction   (if_instruction),
    .if_valid         (if_valid),
    .fetch_count      (fetch_count)
`ifdef FETCH_ALIGN_CHECK_EN
    ,
    .fetch_misaligned (fetch_misaligned)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory contents: a few known instructions, otherwise a pattern tagged with the address.
  function automatic logic [31:0] memWord(input logic [31:0] addr);
    case (addr)
      32'h0000_0004: memWord = 32'h00F0_0093;
      32'h0000_0024: memWord = 32'h0030_AA23;
      32'h0000_0034: memWord = 32'h0230_C463;
      default:       memWord = {16'hA5A5, addr[15:0]};
    endcase
  endfunction

  always @(posedge clk) begin
    if (!resetn) imem_instruction <= 32'd0;
    else         imem_instruction <= memWord(imem_address);
  end

  task automatic applyStimulus(input logic rst_n, input logic stl, input logic rv,
                               input logic [31:0] tgt);
    resetn          = rst_n;
    stall           = stl;
    redirect_valid  = rv;
    redirect_target = tgt;
    #1;
  endtask

  task automatic nextCycle;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;

    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    nextCycle();
    nextCycle();
    checkOutput("reset_if_pc", if_pc, 32'h0);
    checkOutput("reset_pc_plus4", if_pc_plus4, 32'h4);
    checkOutput("reset_valid", {31'd0, if_valid}, 32'd0);
    checkOutput("reset_count", fetch_count, 32'd0);

    // Cycle 1 after release: BOOT
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    checkOutput("boot_valid", {31'd0, if_valid}, 32'd0);
    checkOutput("boot_addr", imem_address, 32'h0);

    nextCycle();
    checkOutput("c2_if_pc", if_pc, 32'h0);
    checkOutput("c2_valid", {31'd0, if_valid}, 32'd1);
    checkOutput("c2_instr", if_instruction, memWord(32'h0));
    checkOutput("c2_count", fetch_count, 32'd0);

    nextCycle();
    checkOutput("c3_if_pc", if_pc, 32'h4);
    checkOutput("c3_instr", if_instruction, 32'h00F0_0093);
    checkOutput("c3_pc_plus4", if_pc_plus4, 32'h8);
    checkOutput("c3_count", fetch_count, 32'd1);

    // Three stall cycles holding if_pc=4
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
      checkOutput("stall_addr", imem_address, 32'h4);
      checkOutput("stall_if_pc", if_pc, 32'h4);
      checkOutput("stall_instr", if_instruction, 32'h00F0_0093);
      checkOutput("stall_count", fetch_count, 32'd1);
      nextCycle();
    end
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    checkOutput("release_if_pc", if_pc, 32'h4);
    checkOutput("release_addr", imem_address, 32'h8);
    nextCycle();
    checkOutput("post_stall_if_pc", if_pc, 32'h8);
    checkOutput("post_stall_instr", if_instruction, memWord(32'h8));
    checkOutput("post_stall_count", fetch_count, 32'd2);

    nextCycle();
    nextCycle();
    nextCycle();
    checkOutput("pre_redir_if_pc", if_pc, 32'h14);
    checkOutput("pre_redir_count", fetch_count, 32'd5);

    applyStimulus(1'b1, 1'b0, 1'b1, 32'h34);
    checkOutput("redir_addr", imem_address, 32'h34);
    nextCycle();
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    checkOutput("redir_if_pc", if_pc, 32'h34);
    checkOutput("redir_instr", if_instruction, 32'h0230_C463);
    checkOutput("redir_count", fetch_count, 32'd6);
    nextCycle();
    checkOutput("redir_next_pc", if_pc, 32'h38);
    checkOutput("redir_next_count", fetch_count, 32'd7);

    // Redirect beats stall
    applyStimulus(1'b1, 1'b1, 1'b1, 32'h24);
    checkOutput("rs_addr", imem_address, 32'h24);
    nextCycle();
    checkOutput("rs_if_pc", if_pc, 32'h24);
    checkOutput("rs_instr", if_instruction, 32'h0030_AA23);
    checkOutput("rs_count", fetch_count, 32'd8);

    // Enter HOLD, then reset with a pending redirect
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    nextCycle();
    checkOutput("hold_count", fetch_count, 32'd8);
    applyStimulus(1'b0, 1'b1, 1'b1, 32'h80);
    nextCycle();
    checkOutput("rst_hold_if_pc", if_pc, 32'h0);
    checkOutput("rst_hold_valid", {31'd0, if_valid}, 32'd0);
    checkOutput("rst_hold_count", fetch_count, 32'd0);
    checkOutput("rst_hold_instr", if_instruction, 32'd0);

    // Stall during BOOT keeps the fetch at RESET_PC
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    checkOutput("boot_stall_addr", imem_address, 32'h0);
    nextCycle();
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    checkOutput("boot_stall_valid", {31'd0, if_valid}, 32'd0);
    checkOutput("boot_release_addr", imem_address, 32'h0);
    nextCycle();
    checkOutput("boot_after_pc", if_pc, 32'h0);
    checkOutput("boot_after_valid", {31'd0, if_valid}, 32'd1);
    checkOutput("boot_after_count", fetch_count, 32'd0);

    // Wraparound at the top of the address space
    applyStimulus(1'b1, 1'b0, 1'b1, 32'hFFFF_FFFC);
    nextCycle();
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    checkOutput("wrap_if_pc", if_pc, 32'hFFFF_FFFC);
    checkOutput("wrap_pc_plus4", if_pc_plus4, 32'h0);
    checkOutput("wrap_addr", imem_address, 32'h0);
    checkOutput("wrap_count", fetch_count, 32'd1);
    nextCycle();
    checkOutput("wrap_next_pc", if_pc, 32'h0);
    checkOutput("wrap_next_count", fetch_count, 32'd2);

    // Unaligned redirect target
    applyStimulus(1'b1, 1'b0, 1'b1, 32'h16);
`ifdef FETCH_ALIGN_CHECK_EN
    checkOutput("align_addr", imem_address, 32'h14);
    checkOutput("align_flag_before", {31'd0, fetch_misaligned}, 32'd0);
    nextCycle();
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    checkOutput("align_if_pc", if_pc, 32'h14);
    checkOutput("align_flag", {31'd0, fetch_misaligned}, 32'd1);
    nextCycle();
    nextCycle();
    checkOutput("align_sticky", {31'd0, fetch_misaligned}, 32'd1);
`else
    checkOutput("unaligned_addr", imem_address, 32'h16);
    nextCycle();
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    checkOutput("unaligned_if_pc", if_pc, 32'h16);
    checkOutput("unaligned_pc_plus4", if_pc_plus4, 32'h1A);
    nextCycle();
    checkOutput("unaligned_next_pc", if_pc, 32'h1A);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
PC generation and fetch sequencing stage, directly upstream of Instruction_Memory.
- Owns the fetch PC and drives the memory address.
- Compensates for the memory's 1-cycle registered read, so the PC tag always matches the returned instruction.
- Presents {pc, pc+4, instruction, valid} to the IF/ID register.
- Handles decode stalls and EX-stage redirects (branch/jal/jalr).

Parameters:
RESET_PC, 32'h00000000, first fetch address after reset
PC_STEP, 4, sequential PC increment in bytes

Ports:
clk  input  1  clock, rising edge
resetn  input  1  synchronous active-low reset
stall  input  1  IF/ID cannot accept; hold current output
redirect_valid  input  1  EX requests PC change this cycle
redirect_target  input  32  new fetch address
imem_address  output  32  to Instruction_Memory adddress (combinational)
imem_instruction  input  32  from Instruction_Memory instruction (registered inside memory)
if_pc  output  32  PC of if_instruction
if_pc_plus4  output  32  if_pc + PC_STEP
if_instruction  output  32  equals imem_instruction (pass-through)
if_valid  output  1  if_instruction is a real fetched instruction
fetch_count  output  32  count of instructions handed to IF/ID
fetch_misaligned  output  1  only present with FETCH_ALIGN_CHECK_EN

Behaviour:
- Interface: single clock clk; resetn is synchronous, active-low. All state updates on posedge clk.
- Internal registers:
  - pc_f: next address to request.
  - pc_d: address whose data is currently on imem_instruction.
  - valid_d.
  - state in {BOOT, RUN, HOLD}.
  - fetch_count.
- Reset (resetn=0 at edge): pc_f=RESET_PC, pc_d=RESET_PC, valid_d=0, state=BOOT, fetch_count=0. Hence if_pc=RESET_PC, if_pc_plus4=RESET_PC+4, if_valid=0. Memory outputs 0 during reset.
- imem_address mux, priority high to low:
  - redirect_valid -> redirect_target
  - stall -> pc_d (replay, so memory keeps returning inst(pc_d))
  - otherwise -> pc_f
- Latency: the instruction for the address driven in cycle N appears on if_instruction in cycle N+1 with if_pc = that address.
- Next-state rules, priority high to low:
  - redirect: pc_d<=redirect_target, pc_f<=redirect_target+PC_STEP, valid_d<=1, state<=RUN. Redirect overrides stall. The instruction on the output in the redirect cycle is not squashed here; the downstream flush handles it.
  - stall (state RUN or HOLD): pc_f, pc_d, valid_d held; state<=HOLD.
  - else: pc_d<=pc_f, pc_f<=pc_f+PC_STEP, valid_d<=1, state<=RUN.
- BOOT: first cycle after reset release.
  - Drives pc_f=RESET_PC; if_valid=0.
  - Exits to RUN (or HOLD if stall) at the next edge; stall in BOOT holds pc_f at RESET_PC.
- HOLD -> RUN when stall=0 at an edge. The output instruction is unchanged throughout HOLD.
- if_valid = valid_d.
- fetch_count increments by 1 at an edge where if_valid=1 and stall=0 (the handoff); it also increments on a redirect edge. It wraps at 2^32 and is cleared only by reset.
- Arithmetic: 32-bit modulo. pc_f=32'hFFFFFFFC advances to 0 with no error.
- Reset mid-operation (any state): returns to the reset values on that edge; pending stall/redirect are ignored.

Optional Feature:
Macro FETCH_ALIGN_CHECK_EN.
- Defined:
  - fetch_misaligned port exists; it is registered, reset 0, and set to 1 at an edge where redirect_valid=1 and redirect_target[1:0]!=0.
  - The redirected pc_d/pc_f use redirect_target with [1:0] forced to 0, and imem_address is aligned likewise.
  - fetch_misaligned stays 1 until reset (sticky).
- Undefined: port absent; targets are used unmodified; no check logic.

Test Plan:
- Reset then release, memory word 4 = 0x00F00093: cycle 1 if_valid=0. Cycle 2 if_pc=0, if_valid=1. Cycle 3 if_pc=4, if_instruction=0x00F00093, if_pc_plus4=8.
- Stall for 3 cycles while if_pc=4: imem_address=4 each stall cycle; if_pc=4, instruction=0x00F00093 held, fetch_count frozen. Release: next cycle if_pc=8.
- redirect_valid=1, target=0x34 while if_pc=0x14: same-cycle imem_address=0x34; next cycle if_pc=0x34, if_instruction=0x0230C463, then if_pc=0x38.
- Redirect and stall together, target=0x24: redirect wins; next if_pc=0x24, if_instruction=0x0030AA23.
- resetn=0 asserted while in HOLD: next cycle if_pc=RESET_PC, if_valid=0, fetch_count=0.
- FETCH_ALIGN_CHECK_EN, target=0x16: fetch_misaligned=1 next cycle, if_pc=0x14, and it stays set.
